// File: rtl/priority_arbiter.sv
// Eight-way request arbiter with fixed or rotating priority, a per-tenure hold limit
// and one-shot preemption of a requester whose tenure was ended by the hold limit.
module priority_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned RR_MODE  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned NREQ = 8;
    localparam int unsigned IDW  = 3;
    localparam int unsigned CNTW = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state, state_d;
    logic [NREQ-1:0]   gnt_d;
    logic [IDW-1:0]    gnt_id_d;
    logic              busy_d;
    logic              timeout_d;
    logic [CNTW-1:0]   cnt, cnt_d;
    logic [IDW-1:0]    last_id, last_id_d;
    logic [NREQ-1:0]   pmask, pmask_d;

    logic [NREQ-1:0]   elig;
    logic [IDW-1:0]    idx;
    logic [IDW-1:0]    win_id;
    logic              win_found;

    // Winner search; a timed-out requester is skipped only when someone else is asking
    always_comb begin
        elig      = req & ~pmask;
        if (elig == '0) begin
            elig = req;
        end
        idx       = '0;
        win_id    = '0;
        win_found = 1'b0;
        if (RR_MODE != 0) begin
            for (int unsigned i = 1; i <= NREQ; i++) begin
                idx = last_id - IDW'(i);
                if (!win_found && elig[idx]) begin
                    win_found = 1'b1;
                    win_id    = idx;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (elig[IDW'(i)]) begin
                    win_found = 1'b1;
                    win_id    = IDW'(i);
                end
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        gnt_id_d  = gnt_id;
        busy_d    = busy;
        timeout_d = 1'b0;
        cnt_d     = cnt;
        last_id_d = last_id;
        pmask_d   = pmask;
        case (state)
            IDLE: begin
                if (enable && win_found) begin
                    state_d   = GRANT;
                    gnt_d     = NREQ'(1) << win_id;
                    gnt_id_d  = win_id;
                    busy_d    = 1'b1;
                    cnt_d     = CNTW'(1);
                    last_id_d = win_id;
                    pmask_d   = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    pmask_d = '0;
                end else if (cnt == CNTW'(MAX_HOLD)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    pmask_d   = gnt;
                end else begin
                    cnt_d = cnt + CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
            last_id <= '0;
            pmask   <= '0;
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            busy    <= busy_d;
            timeout <= timeout_d;
            cnt     <= cnt_d;
            last_id <= last_id_d;
            pmask   <= pmask_d;
        end
    end

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: a fixed-priority and a rotating instance share stimulus;
// a behavioural model feeds per-instance scoreboards checked by a negedge monitor.
module tb_priority_arbiter;

    localparam int unsigned MH = 4;
    localparam int NI = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;
    logic [7:0] gnt     [NI];
    logic [2:0] gnt_id  [NI];
    logic       busy    [NI];
    logic       timeout [NI];

    typedef struct {
        logic [7:0] gnt;
        int         id;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   log0[$];
    int   log1[$];
    int   to_cnt [NI];
    logic prev_busy [NI];

    // Reference model state: owner -1 means nobody holds the grant
    int         m_owner [NI];
    int         m_len   [NI];
    int         m_last  [NI];
    logic [7:0] m_mask  [NI];

    int checks = 0;
    int errors = 0;

    logic [7:0] held, nr;
    int         wait_n;

    always #5 clk = ~clk;

    priority_arbiter #(.MAX_HOLD(MH), .RR_MODE(0)) u_fixed (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .gnt(gnt[0]), .gnt_id(gnt_id[0]), .busy(busy[0]), .timeout(timeout[0])
    );

    priority_arbiter #(.MAX_HOLD(MH), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .gnt(gnt[1]), .gnt_id(gnt_id[1]), .busy(busy[1]), .timeout(timeout[1])
    );

    task automatic check(input string nm, input bit ok, input string act, input string exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %s required %s", nm, act, exp);
        end
    endtask

    // Priority order as a list of indices, first eligible one wins
    function automatic int pick(input logic [7:0] cand, input int rr, input int lst);
        int p;
        for (int k = 1; k <= 8; k++) begin
            if (rr != 0) p = ((lst - k) % 8 + 8) % 8;
            else         p = 8 - k;
            if (cand[p]) return p;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < NI; m++) begin
            exp_t       e;
            logic [7:0] cand;
            int         w;
            e.to = 1'b0;
            if (!rst_n) begin
                m_owner[m] = -1;
                m_len[m]   = 0;
                m_last[m]  = 0;
                m_mask[m]  = '0;
            end else if (m_owner[m] < 0) begin
                if (enable && req != 8'h00) begin
                    cand = req & ~m_mask[m];
                    if (cand == 8'h00) cand = req;
                    w = pick(cand, m, m_last[m]);
                    m_owner[m] = w;
                    m_len[m]   = 1;
                    m_last[m]  = w;
                    m_mask[m]  = '0;
                end
            end else if (!req[m_owner[m]]) begin
                m_owner[m] = -1;
                m_mask[m]  = '0;
            end else if (m_len[m] == int'(MH)) begin
                m_mask[m]  = 8'h01 << m_owner[m];
                m_owner[m] = -1;
                e.to       = 1'b1;
            end else begin
                m_len[m]++;
            end
            e.busy = (m_owner[m] >= 0);
            e.id   = e.busy ? m_owner[m] : 0;
            e.gnt  = e.busy ? (8'h01 << m_owner[m]) : 8'h00;
            if (m == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int m = 0; m < NI; m++) begin
            exp_t e;
            bit   have;
            have = (m == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
            if (!have) begin
                check($sformatf("sb_empty%0d", m), 1'b0, "no expectation", "queued expectation");
            end else begin
                if (m == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                check($sformatf("cycle%0d", m),
                      gnt[m] == e.gnt && busy[m] == e.busy && timeout[m] == e.to &&
                      (!e.busy || int'(gnt_id[m]) == e.id),
                      $sformatf("gnt=%02h id=%0d busy=%0b to=%0b @%0t", gnt[m], gnt_id[m], busy[m], timeout[m], $time),
                      $sformatf("gnt=%02h id=%0d busy=%0b to=%0b", e.gnt, e.id, e.busy, e.to));
            end
        end
    end

    // Tenure log: granted index at each grant start, plus timeout pulse count
    always @(negedge clk) begin
        for (int m = 0; m < NI; m++) begin
            if (busy[m] === 1'b1 && prev_busy[m] !== 1'b1) begin
                if (m == 0) log0.push_back(int'(gnt_id[m]));
                else        log1.push_back(int'(gnt_id[m]));
            end
            if (timeout[m] === 1'b1) to_cnt[m]++;
            prev_busy[m] = busy[m];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        to_cnt[0] = 0;
        to_cnt[1] = 0;
    endtask

    task automatic check_log(input string nm, input int m, input int e[$]);
        int got[$];
        bit ok;
        if (m == 0) got = log0;
        else        got = log1;
        ok = (got.size() == e.size());
        foreach (e[i]) if (ok && got[i] != e[i]) ok = 1'b0;
        check(nm, ok, $sformatf("%p", got), $sformatf("%p", e));
    endtask

    initial begin
        int e[$];
        to_cnt[0] = 0;
        to_cnt[1] = 0;
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = 8'hFF;
        tick(3);
        for (int m = 0; m < NI; m++) begin
            check($sformatf("reset%0d", m),
                  gnt[m] == 8'h00 && gnt_id[m] == 3'd0 && busy[m] == 1'b0 && timeout[m] == 1'b0,
                  $sformatf("gnt=%02h id=%0d busy=%0b to=%0b", gnt[m], gnt_id[m], busy[m], timeout[m]),
                  "gnt=00 id=0 busy=0 to=0");
        end
        rst_n = 1'b1;
        req   = 8'h00;
        tick(2);

        // Fixed priority: 5 wins, then 2 after req[5] drops
        clear_logs();
        req = 8'b0010_0101;
        tick(3);
        req = 8'b0000_0101;
        tick(4);
        e = {5, 2};
        check_log("fixed_order", 0, e);
        check("fixed_gnt2", gnt[0] == 8'h04, $sformatf("%02h", gnt[0]), "04");
        req = 8'h00;
        tick(3);

        // Hold limit with two requesters: 3 times out, 1 gets its turn
        clear_logs();
        req = 8'b0000_1010;
        tick(12);
        e = {3, 1, 3};
        check_log("timeout_order", 0, e);
        check("timeout_count", to_cnt[0] == 2, $sformatf("%0d", to_cnt[0]), "2");
        req = 8'h00;
        tick(3);

        // Sole requester is re-granted after each timeout
        clear_logs();
        req = 8'h40;
        tick(14);
        e = {6, 6, 6};
        check_log("sole_regrant", 0, e);
        check("sole_timeouts", to_cnt[0] == 2, $sformatf("%0d", to_cnt[0]), "2");
        req = 8'h00;
        tick(1);
        check("release_at_max", timeout[0] == 1'b0 && busy[0] == 1'b0,
              $sformatf("to=%0b busy=%0b", timeout[0], busy[0]), "to=0 busy=0");
        tick(2);

        // Rotating sequence with 2-cycle tenures, starting from a fresh reset
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        clear_logs();
        req = 8'hFF;
        for (int t = 0; t < 9; t++) begin
            wait_n = 0;
            while (!busy[1] && wait_n < 10) begin
                tick(1);
                wait_n++;
            end
            if (!busy[1]) begin
                check("rr_grant_wait", busy[1], "no grant in 10 cycles", "grant");
                break;
            end
            tick(1);
            req = 8'hFF & ~(8'h01 << gnt_id[1]);
            tick(1);
            req = 8'hFF;
        end
        e = {7, 6, 5, 4, 3, 2, 1, 0, 7};
        check_log("rr_sequence", 1, e);
        req = 8'h00;
        tick(3);

        // Enable gating, reset mid-tenure, rotating search restart
        clear_logs();
        enable = 1'b0;
        req    = 8'h01;
        tick(4);
        check("enable_low", busy[0] == 1'b0 && busy[1] == 1'b0 && log0.size() == 0 && log1.size() == 0,
              $sformatf("busy=%0b/%0b grants=%0d/%0d", busy[0], busy[1], log0.size(), log1.size()),
              "busy=0/0 grants=0/0");
        enable = 1'b1;
        tick(2);
        e = {0};
        check_log("enable_fixed", 0, e);
        check_log("enable_rr", 1, e);
        req = 8'h00;
        tick(3);
        req = 8'h08;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        for (int m = 0; m < NI; m++) begin
            check($sformatf("reset_mid%0d", m), gnt[m] == 8'h00 && busy[m] == 1'b0,
                  $sformatf("gnt=%02h busy=%0b", gnt[m], busy[m]), "gnt=00 busy=0");
        end
        rst_n = 1'b1;
        clear_logs();
        req = 8'hFF;
        tick(2);
        e = {7};
        check_log("rr_restart", 1, e);
        req = 8'h00;
        tick(3);

        // Randomized traffic with occasional resets and enable drops
        for (int c = 0; c < 3000; c++) begin
            held = gnt[0] | gnt[1];
            nr   = req;
            for (int i = 0; i < 8; i++) begin
                if (held[i]) begin
                    if ($urandom_range(0, 7) == 0) nr[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    nr[i] = ~nr[i];
                end
            end
            req    = nr;
            enable = ($urandom_range(0, 9) != 0);
            rst_n  = ($urandom_range(0, 199) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive grant cycles per tenure; legal range 2..255.
REQ-002 Parameter RR_MODE, default 0: 0 = fixed priority, 1 = rotating priority.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  permits new grants; does not revoke an active grant.
REQ-006 req  input  8  request per requester; requester holds it high for the whole tenure.
REQ-007 gnt  output  8  one-hot grant, registered.
REQ-008 gnt_id  output  3  index of granted requester, registered; valid when busy=1.
REQ-009 busy  output  1  high while any gnt bit is high.
REQ-010 timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD.

Function
REQ-011 States SHALL be IDLE and GRANT only; gnt, gnt_id and busy SHALL all be registered outputs of that state.
REQ-012 IDLE: with enable=1 and any eligible req bit set on edge k, the block SHALL enter GRANT with gnt/gnt_id/busy valid after edge k (1-cycle latency).
REQ-013 IDLE: with enable=0 or no eligible req, the block SHALL stay in IDLE with gnt=0, busy=0.
REQ-014 Fixed priority: the winner SHALL be the highest set index (req[7] highest, req[0] lowest).
REQ-015 Rotating priority: the search SHALL start at last_id-1 and proceed downward with wrap (0 -> 7), ending at last_id; the first set bit wins.
REQ-016 last_id SHALL load the winner index on every grant; its reset value SHALL be 0, so the first rotating search starts at index 7.
REQ-017 GRANT: the hold counter SHALL load 1 on grant entry and increment on each further GRANT cycle.
REQ-018 GRANT: if req[gnt_id] is sampled low, the block SHALL clear gnt/busy on that edge and return to IDLE.
REQ-019 GRANT: if req[gnt_id] is high and the counter equals MAX_HOLD, the block SHALL clear gnt/busy, pulse timeout for one cycle on that edge, and return to IDLE; gnt is high for exactly MAX_HOLD cycles.
REQ-020 After any release, gnt SHALL stay 0 for at least one full cycle before the next grant; back-to-back tenures therefore have a 1-cycle gap.
REQ-021 Preemption: the requester ended by timeout SHALL be ineligible for the next arbitration only if another req bit is set; if it is the sole requester, it SHALL be re-granted.
REQ-022 The preemption mask SHALL clear after one arbitration, or on a voluntary release.
REQ-023 Changes to req bits other than req[gnt_id] during GRANT SHALL have no effect on the grant.
REQ-024 enable falling during GRANT SHALL not end the tenure; it SHALL block only the next arbitration.
REQ-025 Release and timeout on the same edge (req[gnt_id] low at count=MAX_HOLD) SHALL be treated as a voluntary release: timeout=0 and no preemption mask.
REQ-026 gnt SHALL always be 0 or one-hot, and gnt[gnt_id] SHALL equal busy.

Reset
REQ-027 rst_n=0 sampled on a clock edge SHALL force IDLE with gnt=0, gnt_id=0, busy=0, timeout=0, hold counter=0, last_id=0 and preemption mask cleared, including when it arrives mid-tenure.
REQ-028 While rst_n=0, req and enable SHALL be ignored; arbitration SHALL begin on the first edge with rst_n=1.

Verification
REQ-029 Fixed priority: req=8'b0010_0101 held, enable=1 -> one cycle later gnt=8'b0010_0000, gnt_id=5; drop req[5] -> gnt=0 for 1 cycle, then gnt_id=2.
REQ-030 Timeout, MAX_HOLD=4: req[3] and req[1] both held -> gnt_id=3 for exactly 4 cycles with timeout pulsed on the drop edge, 1-cycle gap, then gnt_id=1.
REQ-031 Sole requester timeout, MAX_HOLD=4: only req[6] held -> 4 cycles granted, 1 gap, re-granted to 6, repeating with timeout each tenure.
REQ-032 Rotating priority, RR_MODE=1: req=8'hFF held, each tenure released after 2 cycles -> gnt_id sequence 7,6,5,4,3,2,1,0,7.
REQ-033 Enable and reset: enable=0 with req=8'h01 -> gnt stays 0; enable=1 -> gnt_id=0; rst_n=0 mid-tenure -> gnt=0, busy=0 on that edge; after release with rst_n=1, the RR search restarts from index 7.
